// File: rtl/tt_sweep_capture.sv
// Clocked truth-table sweep: drives all 16 {a,b,c,d} vectors into a 4-input block,
// samples f at the end of each hold window and checks the table against EXPECTED.
// Optional macro TT_SWEEP_ERRCNT_EN adds the err_cnt mismatch-count output.
module tt_sweep_capture #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        pass,
  output logic [3:0]  fail_idx
`ifdef TT_SWEEP_ERRCNT_EN
  ,
  output logic [4:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tab_q, tab_d;
  logic [15:0] tab_cap;
  logic [15:0] diff;
  logic        pass_q, pass_d;
  logic [3:0]  fidx_q, fidx_d;
  logic [3:0]  vec_q, vec_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  err_q, err_d;

  function automatic logic [3:0] lowest_set(input logic [15:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (x[k]) r = k[3:0];
    end
    return r;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] x);
    logic [4:0] r;
    r = 5'd0;
    for (int k = 0; k < 16; k++) begin
      r = r + 5'(x[k]);
    end
    return r;
  endfunction

  // Table as it will look after the current sample is written; results at the
  // DONE entry edge are taken from this so they are valid during DONE itself.
  always_comb begin
    tab_cap        = tab_q;
    tab_cap[idx_q] = f;
    diff           = tab_cap ^ EXPECTED;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tab_d   = tab_q;
    pass_d  = pass_q;
    fidx_d  = fidx_q;
    err_d   = err_q;
    vec_d   = 4'd0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          tab_d   = 16'd0;
          pass_d  = 1'b0;
          fidx_d  = 4'd0;
          err_d   = 5'd0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        busy_d = 1'b1;
        vec_d  = idx_q;
        if (cnt_q == LAST_CNT) begin
          tab_d = tab_cap;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            busy_d  = 1'b0;
            vec_d   = 4'd0;
            done_d  = 1'b1;
            pass_d  = (diff == 16'd0);
            fidx_d  = lowest_set(diff);
            err_d   = popcount(diff);
          end else begin
            idx_d = idx_q + 4'd1;
            cnt_d = 8'd0;
            vec_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      tab_q   <= 16'd0;
      pass_q  <= 1'b0;
      fidx_q  <= 4'd0;
      err_q   <= 5'd0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tab_q   <= tab_d;
      pass_q  <= pass_d;
      fidx_q  <= fidx_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign truth_table  = tab_q;
  assign pass         = pass_q;
  assign fail_idx     = fidx_q;

`ifdef TT_SWEEP_ERRCNT_EN
  assign err_cnt = err_q;
`else
  logic unused_err;
  assign unused_err = ^err_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench: three sweepers in lockstep (pass case, single-bit miss, f tied high);
// the stimulus queues sweep start edges, a monitor checks vectors, timing and results.
module tb_tt_sweep_capture;
  localparam int H = 4;
  localparam int SWEEP_LEN = 16 * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic glitch = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   exp_q[$];

  logic a0, b0, c0, d0, busy0, done0, pass0, f0;
  logic a1, b1, c1, d1, busy1, done1, pass1, f1;
  logic a2, b2, c2, d2, busy2, done2, pass2, f2;
  logic [15:0] tab0, tab1, tab2;
  logic [3:0]  fi0, fi1, fi2;
`ifdef TT_SWEEP_ERRCNT_EN
  logic [4:0]  ec0, ec1, ec2;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Glitches f everywhere except the sampled last hold cycle.
  assign f0 = ((a0 & b0) | (c0 & ~d0)) ^ glitch;
  assign f1 = ((a1 & b1) | (c1 & ~d1)) ^ glitch;
  assign f2 = 1'b1 ^ glitch;

  tt_sweep_capture #(.HOLD_CYCLES(H), .EXPECTED(16'hF444)) u0 (
    .clk(clk), .rst(rst), .start(start), .f(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .truth_table(tab0), .pass(pass0), .fail_idx(fi0)
`ifdef TT_SWEEP_ERRCNT_EN
    , .err_cnt(ec0)
`endif
  );

  tt_sweep_capture #(.HOLD_CYCLES(H), .EXPECTED(16'hF440)) u1 (
    .clk(clk), .rst(rst), .start(start), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .truth_table(tab1), .pass(pass1), .fail_idx(fi1)
`ifdef TT_SWEEP_ERRCNT_EN
    , .err_cnt(ec1)
`endif
  );

  tt_sweep_capture #(.HOLD_CYCLES(H), .EXPECTED(16'h0000)) u2 (
    .clk(clk), .rst(rst), .start(start), .f(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .truth_table(tab2), .pass(pass2), .fail_idx(fi2)
`ifdef TT_SWEEP_ERRCNT_EN
    , .err_cnt(ec2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (busy0 && exp_q.size() > 0)
      glitch = (((cyc - exp_q[0]) % H) != H - 1);
    else
      glitch = 1'b0;
  end

  always @(posedge clk) begin
    int rel;
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0 && cyc >= exp_q[0]) begin
        rel = cyc - exp_q[0];
        if (rel < SWEEP_LEN) begin
          chk("sweep_busy", 32'(busy0), 32'd1);
          chk("sweep_done", 32'(done0), 32'd0);
          chk("sweep_vec", 32'({a0, b0, c0, d0}), 32'(rel / H));
          chk("sweep_pass_clr", 32'(pass0), 32'd0);
          chk("sweep_fidx_clr", 32'(fi1), 32'd0);
          if (rel == 0) chk("sweep_tab_clr", 32'(tab0), 32'd0);
        end else begin
          chk("done_u0", 32'(done0), 32'd1);
          chk("done_u1", 32'(done1), 32'd1);
          chk("done_u2", 32'(done2), 32'd1);
          chk("done_busy", 32'(busy0), 32'd0);
          chk("done_vec", 32'({a0, b0, c0, d0}), 32'd0);
          chk("u0_table", 32'(tab0), 32'hF444);
          chk("u0_pass", 32'(pass0), 32'd1);
          chk("u0_fidx", 32'(fi0), 32'd0);
          chk("u1_table", 32'(tab1), 32'hF444);
          chk("u1_pass", 32'(pass1), 32'd0);
          chk("u1_fidx", 32'(fi1), 32'd2);
          chk("u2_table", 32'(tab2), 32'hFFFF);
          chk("u2_pass", 32'(pass2), 32'd0);
          chk("u2_fidx", 32'(fi2), 32'd0);
`ifdef TT_SWEEP_ERRCNT_EN
          chk("u0_errcnt", 32'(ec0), 32'd0);
          chk("u1_errcnt", 32'(ec1), 32'd1);
          chk("u2_errcnt", 32'(ec2), 32'd16);
`endif
          $display("sweep started at edge %0d completed at cycle %0d: table %h pass %0b", exp_q[0], cyc, tab0, pass0);
          done_seen++;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_busy", 32'(busy0), 32'd0);
        chk("idle_done", 32'(done0 | done1 | done2), 32'd0);
        chk("idle_vec", 32'({a0, b0, c0, d0}), 32'd0);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"}, 32'({a0, b0, c0, d0}), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_table"}, 32'(tab0), 32'd0);
    chk({tag, "_pass"}, 32'(pass0), 32'd0);
    chk({tag, "_fidx"}, 32'(fi1), 32'd0);
`ifdef TT_SWEEP_ERRCNT_EN
    chk({tag, "_errcnt"}, 32'(ec2), 32'd0);
`endif
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout at cycle %0d: got %0d pending sweeps expected 0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("reset");
    $display("reset and idle checked at cycle %0d", cyc);

    // Sweep with a stray start pulse in the middle.
    go();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty(200);
    repeat (4) @(negedge clk);

    // Abort during vector 7; monitor then expects no done.
    go();
    repeat (29) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("abort");
    $display("reset mid-sweep at cycle %0d", cyc);
    repeat (80) @(negedge clk);

    // start held high: back-to-back sweeps with one idle cycle between.
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    exp_q.push_back(t);
    exp_q.push_back(t + SWEEP_LEN + 2);
    while (cyc < t + SWEEP_LEN + 12) @(negedge clk);
    start = 1'b0;
    wait_empty(200);
    repeat (5) @(negedge clk);

    chk("hold_u0_pass", 32'(pass0), 32'd1);
    chk("hold_u1_pass", 32'(pass1), 32'd0);
    chk("hold_u1_fidx", 32'(fi1), 32'd2);
    chk("done_count", 32'(done_seen), 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential stimulus-and-capture stage for a 4-input combinational gate-level block f(a,b,c,d).
- Sits directly upstream of the block under test, driving all 16 input combinations in order (a = MSB, d = LSB), and directly downstream of it, sampling f for each combination.
- Builds a 16-bit captured truth table and compares it against a parameterised expected table, reporting done/pass.
- Replaces hand-written #100 stimulus sequences with a clocked, self-checking sweep.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is held before f is sampled; legal range 2..255.
- EXPECTED, 16'h0000, expected truth table; bit k is the required f for {a,b,c,d} = k.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- f  input  1  output of the block under test.
- a  output  1  stimulus bit 3 (MSB of vector index).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0 (LSB).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table  output  16  captured truth table; bit k = f sampled for vector k.
- pass  output  1  table == EXPECTED; valid from done onward.
- fail_idx  output  4  lowest index k with table[k] != EXPECTED[k]; 0 when pass = 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; it is sampled on the rising edge of clk.
- Reset values: state = IDLE; a, b, c, d = 0; busy = 0; done = 0; table = 0; pass = 0; fail_idx = 0; idx = 0; hold counter = 0.
- States:
  - IDLE: a..d = 0, busy = 0. start = 1 -> SWEEP with idx = 0 and hold counter = 0.
  - SWEEP: busy = 1; {a,b,c,d} = idx, registered.
    - Hold counter runs 0..HOLD_CYCLES-1.
    - On the edge ending the cycle where the counter = HOLD_CYCLES-1, table[idx] <= f.
    - On that same edge: if idx < 15, idx increments and the counter clears; if idx = 15, go to DONE.
  - DONE: exactly one cycle. done = 1, busy = 0, a..d = 0. pass and fail_idx are valid and computed from the completed table. Next state IDLE.
- Timing: if start is seen at edge T, vector k is driven during cycles T+1+k*H through T+(k+1)*H, where H = HOLD_CYCLES. done is high in cycle T+16H+1.
- Table update: table is cleared to 0 on sweep entry. Bits are written progressively, so partial contents are visible during SWEEP.
- Result hold: pass and fail_idx are cleared on sweep entry and updated only in DONE. They hold until the next start or rst.
- start while busy = 1 or in DONE: ignored, not queued.
- start held high continuously: a new sweep begins in the first IDLE cycle after DONE, giving back-to-back sweeps with one IDLE cycle between them.
- rst mid-sweep: abort immediately. All outputs take their reset values and no done pulse is issued.
- f is not sampled outside the last hold cycle. Glitches earlier in the hold window have no effect.
- fail_idx: priority encoder over table ^ EXPECTED, selecting the lowest set bit.

Optional Feature:
- Macro: TT_SWEEP_ERRCNT_EN.
- Defined:
  - Adds output err_cnt, 5 bits: the population count of table ^ EXPECTED, range 0..16.
  - err_cnt is updated in DONE, cleared on sweep entry and on rst, and holds otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> a..d = 0, busy = 0, done = 0, table = 0, pass = 0.
- Bench f = (a&b)|(c&~d), EXPECTED = 16'hF444, H = 4, start pulse at edge T -> vectors 0..15 in order, each held 4 cycles; done in cycle T+65; table = 16'hF444; pass = 1; fail_idx = 0.
- Same f with EXPECTED = 16'hF440 -> table = 16'hF444, pass = 0, fail_idx = 2; with the macro defined, err_cnt = 1.
- Bench f tied to 1, EXPECTED = 16'h0000 -> table = 16'hFFFF, pass = 0, fail_idx = 0; with the macro defined, err_cnt = 16.
- Assert rst during vector 7 -> next cycle all outputs at reset values, no done; a later start runs a full fresh sweep.
- start pulsed again mid-sweep, and start held high through done -> mid-sweep pulse ignored; second sweep starts with vector 0 driven two cycles after done; no missing or extra done pulses.
